// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

   localparam int HZ_REG_AW  = 5;
   localparam int HZ_WAIT_W  = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   typedef enum logic {
      RUN       = 1'b0,
      DMEM_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - EX operand forwarding compare for one source register
module fwd_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW = HZ_REG_AW
) (
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   output logic [1:0]        sel
);

   // MEM holds the younger result, so it wins over WB; x0 is never forwarded
   always_comb begin
      sel = FWD_RF;
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
         sel = FWD_MEM;
      end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding control for the 5-stage pipeline
// Optional performance counters: HAZARD_PERF_CNT_EN
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW   = HZ_REG_AW,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_redirect,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic              ex_redirect,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic              mem_req,
   input  logic              dmem_ready,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              mem_wb_bubble,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              dmem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt_stall,
   output logic [CNT_W-1:0]  cnt_flush,
   output logic [CNT_W-1:0]  cnt_fwd
`endif
);

   localparam logic [HZ_WAIT_W-1:0] WAIT_LIMIT = HZ_WAIT_W'(MAX_WAIT);
   localparam logic [HZ_WAIT_W-1:0] WAIT_ONE   = {{(HZ_WAIT_W-1){1'b0}}, 1'b1};

   hz_state_e              state, state_nxt;
   logic [HZ_WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic                   timeout_set;
   logic                   mem_stall;
   logic                   load_use;
   logic                   lu_stall;
   logic [1:0]             fwd_a_raw, fwd_b_raw;

   // ex_regwrite is carried for datapath symmetry; load-use keys on ex_memread alone
   logic unused_inputs;
   assign unused_inputs = ex_regwrite;

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .ex_rs        (ex_rs1),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_a_raw)
   );

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .ex_rs        (ex_rs2),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_b_raw)
   );

   assign load_use = ex_memread && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= '0;
         dmem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (timeout_set) begin
            dmem_timeout <= 1'b1;
         end
      end
   end

   // A timed-out access releases the pipeline in the same cycle, like a late ready
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_set  = 1'b0;
      mem_stall    = 1'b0;
      case (state)
         RUN: begin
            wait_cnt_nxt = '0;
            if (mem_req && !dmem_ready) begin
               mem_stall = 1'b1;
               state_nxt = DMEM_WAIT;
            end
         end
         DMEM_WAIT: begin
            if (dmem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WAIT_LIMIT) begin
               timeout_set  = 1'b1;
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else begin
               mem_stall    = 1'b1;
               wait_cnt_nxt = wait_cnt + WAIT_ONE;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      lu_stall      = 1'b0;
      fwd_a         = FWD_RF;
      fwd_b         = FWD_RF;
      if (!rst) begin
         fwd_a = fwd_a_raw;
         fwd_b = fwd_b_raw;
         if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
         end else if (ex_redirect) begin
            // the load-use dependent is squashed here, so its stall is dropped
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            lu_stall    = 1'b1;
         end else if (id_redirect) begin
            if_id_flush = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_stall <= '0;
         cnt_flush <= '0;
         cnt_fwd   <= '0;
      end else begin
         if ((lu_stall || mem_stall) && !(&cnt_stall)) begin
            cnt_stall <= cnt_stall + CNT_ONE;
         end
         if ((if_id_flush || id_ex_flush) && !(&cnt_flush)) begin
            cnt_flush <= cnt_flush + CNT_ONE;
         end
         if (((fwd_a != FWD_RF) || (fwd_b != FWD_RF)) && !(&cnt_fwd)) begin
            cnt_fwd <= cnt_fwd + CNT_ONE;
         end
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt;
   logic             unused_lu;
   assign unused_cnt = '0;
   assign unused_lu  = lu_stall;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int REG_AW   = 5;
   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic              id_use_rs1, id_use_rs2, id_redirect;
   logic              ex_regwrite, ex_memread, ex_redirect;
   logic              mem_regwrite, mem_req, dmem_ready, wb_regwrite;
   logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic              if_id_flush, id_ex_flush, mem_wb_bubble, dmem_timeout;
   logic [1:0]        fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0]  cnt_stall, cnt_flush, cnt_fwd;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_AW   (REG_AW),
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .id_redirect   (id_redirect),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_rd         (ex_rd),
      .ex_regwrite   (ex_regwrite),
      .ex_memread    (ex_memread),
      .ex_redirect   (ex_redirect),
      .mem_rd        (mem_rd),
      .mem_regwrite  (mem_regwrite),
      .mem_req       (mem_req),
      .dmem_ready    (dmem_ready),
      .wb_rd         (wb_rd),
      .wb_regwrite   (wb_regwrite),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .id_ex_en      (id_ex_en),
      .ex_mem_en     (ex_mem_en),
      .if_id_flush   (if_id_flush),
      .id_ex_flush   (id_ex_flush),
      .mem_wb_bubble (mem_wb_bubble),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .dmem_timeout  (dmem_timeout)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .cnt_stall     (cnt_stall),
      .cnt_flush     (cnt_flush),
      .cnt_fwd       (cnt_fwd)
`endif
   );

   // exp = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a, fwd_b}
   typedef struct {
      logic [4:0]  id_rs1;
      logic [4:0]  id_rs2;
      logic        use1;
      logic        use2;
      logic        id_redir;
      logic [4:0]  ex_rs1;
      logic [4:0]  ex_rs2;
      logic [4:0]  ex_rd;
      logic        ex_mr;
      logic        ex_redir;
      logic [4:0]  mem_rd;
      logic        mw;
      logic [4:0]  wb_rd;
      logic        ww;
      logic [10:0] exp;
   } vec_t;

   localparam logic [10:0] RUN_OUT  = 11'b1111_000_00_00;
   localparam logic [10:0] WAIT_OUT = 11'b0000_001_00_00;

   vec_t tv[16];

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_redirect = 1'b0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      ex_redirect = 1'b0; mem_rd = '0; mem_regwrite = 1'b0; mem_req = 1'b0;
      dmem_ready = 1'b1; wb_rd = '0; wb_regwrite = 1'b0;
   endtask

   task automatic chk(input string name, input logic [10:0] exp);
      logic [10:0] act;
      act = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
             mem_wb_bubble, fwd_a, fwd_b};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: outputs got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      tv[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 11'b1111_000_00_00};
      tv[1]  = '{0, 0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 1, 5, 1, 11'b1111_000_01_00};
      tv[2]  = '{0, 0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 0, 5, 1, 11'b1111_000_10_00};
      tv[3]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 11'b1111_000_00_00};
      tv[4]  = '{0, 0, 0, 0, 0,  3, 9, 0, 0, 0,  3, 1, 9, 1, 11'b1111_000_01_10};
      tv[5]  = '{0, 0, 0, 0, 0,  4, 4, 0, 0, 0,  4, 1, 4, 1, 11'b1111_000_01_01};
      tv[6]  = '{0, 7, 0, 1, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0, 11'b0011_010_00_00};
      tv[7]  = '{0, 7, 0, 0, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0, 11'b1111_000_00_00};
      tv[8]  = '{7, 0, 1, 0, 0,  0, 0, 7, 1, 0,  0, 0, 0, 0, 11'b0011_010_00_00};
      tv[9]  = '{7, 0, 1, 0, 0,  0, 0, 7, 0, 0,  0, 0, 0, 0, 11'b1111_000_00_00};
      tv[10] = '{0, 0, 1, 0, 0,  0, 0, 0, 1, 0,  0, 0, 0, 0, 11'b1111_000_00_00};
      tv[11] = '{0, 7, 0, 1, 0,  0, 0, 7, 1, 1,  0, 0, 0, 0, 11'b1111_110_00_00};
      tv[12] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 11'b1111_100_00_00};
      tv[13] = '{0, 7, 0, 1, 1,  0, 0, 7, 1, 0,  0, 0, 0, 0, 11'b0011_010_00_00};
      tv[14] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0, 11'b1111_110_00_00};
      tv[15] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 1,  0, 0, 0, 0, 11'b1111_110_00_00};

      // reset cycle with hostile inputs: outputs must still be the run defaults
      idle();
      rst = 1'b1;
      mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
      ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1;
      #2 chk("reset_outputs", RUN_OUT);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle();
      #2 chk("post_reset_idle", RUN_OUT);
      chk_val("post_reset_timeout", 32'(dmem_timeout), 0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         id_rs1 = tv[i].id_rs1; id_rs2 = tv[i].id_rs2;
         id_use_rs1 = tv[i].use1; id_use_rs2 = tv[i].use2; id_redirect = tv[i].id_redir;
         ex_rs1 = tv[i].ex_rs1; ex_rs2 = tv[i].ex_rs2; ex_rd = tv[i].ex_rd;
         ex_memread = tv[i].ex_mr; ex_redirect = tv[i].ex_redir;
         mem_rd = tv[i].mem_rd; mem_regwrite = tv[i].mw;
         wb_rd = tv[i].wb_rd; wb_regwrite = tv[i].ww;
         #2 chk($sformatf("vec%0d", i), tv[i].exp);
      end

      // data memory wait: entry cycle plus three wait cycles, redirect suppressed
      @(negedge clk);
      idle();
      mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
      #2 chk("dmem_entry", WAIT_OUT);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2 chk($sformatf("dmem_wait%0d", i), WAIT_OUT);
      end
      @(negedge clk);
      dmem_ready = 1'b1; ex_redirect = 1'b0;
      #2 chk("dmem_ready_release", RUN_OUT);
      @(negedge clk);
      mem_req = 1'b0; dmem_ready = 1'b0;
      #2 chk("dmem_back_in_run", RUN_OUT);
      chk_val("dmem_no_timeout", 32'(dmem_timeout), 0);

      // timeout: entry plus MAX_WAIT stalled wait cycles, then release
      @(negedge clk);
      idle();
      mem_req = 1'b1; dmem_ready = 1'b0;
      #2 chk("to_entry", WAIT_OUT);
      for (int i = 0; i < MAX_WAIT; i++) begin
         @(negedge clk);
         #2 chk($sformatf("to_wait%0d", i), WAIT_OUT);
      end
      @(negedge clk);
      #2 chk("to_release", RUN_OUT);
      chk_val("to_flag_before_edge", 32'(dmem_timeout), 0);
      @(negedge clk);
      mem_req = 1'b0;
      #2 chk("to_run_after", RUN_OUT);
      chk_val("to_flag_set", 32'(dmem_timeout), 1);
      @(negedge clk);
      @(negedge clk);
      #2 chk_val("to_flag_sticky", 32'(dmem_timeout), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2 chk_val("to_flag_cleared", 32'(dmem_timeout), 0);

      // reset in the middle of a wait abandons the access
      @(negedge clk);
      idle();
      mem_req = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 chk("rmw_in_wait", WAIT_OUT);
      @(negedge clk);
      rst = 1'b1;
      #2 chk("rmw_reset_cycle", RUN_OUT);
      @(negedge clk);
      rst = 1'b0;
      mem_req = 1'b0;
      #2 chk("rmw_state_run", RUN_OUT);
`ifdef HAZARD_PERF_CNT_EN
      chk_val("rmw_cnt_stall", cnt_stall, 0);
      chk_val("rmw_cnt_flush", cnt_flush, 0);
      chk_val("rmw_cnt_fwd", cnt_fwd, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Generates stall and flush controls for each pipeline register, plus EX operand forwarding selects.
- Generalises the fixed-timing pipeline: the register address width is parametrised, and data memory may take a variable number of cycles (ready handshake with timeout).
- Sits beside the datapath. Its outputs drive the PC enable, the pipeline-register enables/clears and the ALU operand muxes.

Parameters:
- REG_AW, 5, register-index width (5 = 32 registers; x0 is hard-wired zero).
- MAX_WAIT, 15, maximum DMEM_WAIT cycles before timeout (1..255).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock (only clock); reset is synchronous, active-high.
- rst  in  1  synchronous active-high reset.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- id_redirect  in  1  branch/JAL taken, resolved in ID.
- ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_regwrite, ex_memread  in  1  EX-stage control bits.
- ex_redirect  in  1  JALR target resolved in EX.
- mem_rd  in  REG_AW  destination register in MEM.
- mem_regwrite  in  1  MEM-stage write-back control bit.
- mem_req  in  1  MEM stage performs a load or store this cycle.
- dmem_ready  in  1  data memory completes the access.
- wb_rd  in  REG_AW  destination register in WB.
- wb_regwrite  in  1  WB-stage write-back control bit.
- pc_en  out  1  PC register enable.
- if_id_en, id_ex_en, ex_mem_en  out  1  pipeline register enables.
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1  clear the register to a NOP on the next edge.
- fwd_a, fwd_b  out  2  operand select: 0 = register file, 1 = MEM ALU result, 2 = WB write data.
- dmem_timeout  out  1  sticky error flag.

Behaviour:
- FSM states: RUN, DMEM_WAIT. Reset enters RUN and clears dmem_timeout and the wait counter.
- All control outputs are combinational from the registered state and the current inputs (zero added latency). Only state, the wait counter, dmem_timeout and the counters are registered.
- Reset-cycle outputs: all enables = 1, all flushes/bubbles = 0, fwd_a = fwd_b = 0, dmem_timeout = 0.
- Forwarding (x0 excluded, i.e. rd != 0 required):
  - fwd_a = 1 if mem_regwrite and mem_rd == ex_rs1;
  - else 2 if wb_regwrite and wb_rd == ex_rs1;
  - else 0.
  - fwd_b follows the same rule on ex_rs2. MEM has priority over WB.
- Load-use hazard: ex_memread, ex_rd != 0, and ex_rd matches id_rs1 (with id_use_rs1) or id_rs2 (with id_use_rs2). Response for one cycle: pc_en = 0, if_id_en = 0, id_ex_flush = 1.
- DMEM_WAIT entry: in RUN, mem_req = 1 and dmem_ready = 0 enters DMEM_WAIT.
- DMEM_WAIT behaviour:
  - While in DMEM_WAIT (and in that RUN cycle), pc_en, if_id_en, id_ex_en and ex_mem_en are all 0, and mem_wb_bubble = 1.
  - All other hazard and redirect outputs are suppressed.
  - The wait counter increments each cycle.
- DMEM_WAIT exit:
  - dmem_ready = 1: outputs revert to RUN values in the same cycle; next state RUN.
  - Counter reaches MAX_WAIT without ready: set dmem_timeout (sticky until rst) and return to RUN, releasing the pipeline.
- Redirects:
  - ex_redirect: if_id_flush = 1 and id_ex_flush = 1 (two bubbles).
  - id_redirect: if_id_flush = 1 only.
- Priority, highest first: DMEM wait > ex_redirect > load-use > id_redirect. A load-use stall coincident with ex_redirect is dropped, because the dependent instruction is squashed.
- Reset asserted mid-DMEM_WAIT: state goes to RUN on that edge, counter is cleared, and the pending access is abandoned.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three output ports, each CNT_W wide:
  - cnt_stall: load-use plus DMEM-wait cycles;
  - cnt_flush: cycles with any flush asserted;
  - cnt_fwd: cycles with fwd_a or fwd_b nonzero.
- Counters are cleared by rst and saturate at all-ones.
- When not defined, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_e enum: FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2;
  - hz_state_e enum: RUN, DMEM_WAIT;
  - REG_AW default constant.
- One natural sub-module, fwd_unit: purely combinational forwarding compare, instantiated once per operand (twice).

Test Plan:
- Forwarding priority: ex_rs1 = 5, mem_rd = 5 / mem_regwrite = 1, wb_rd = 5 / wb_regwrite = 1 -> fwd_a = 1. Drop mem_regwrite -> fwd_a = 2. Set all rd = 0 -> fwd_a = 0.
- Load-use: ex_memread = 1, ex_rd = 7, id_rs2 = 7, id_use_rs2 = 1 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1; same inputs with id_use_rs2 = 0 -> no stall.
- DMEM wait: mem_req = 1, dmem_ready low for 3 cycles then high -> 4 cycles of ex_mem_en = 0 and mem_wb_bubble = 1; state back to RUN on the ready cycle; dmem_timeout = 0.
- Timeout: MAX_WAIT = 4, dmem_ready held 0 -> dmem_timeout rises after 4 wait cycles and stays high; pipeline enables return to 1; rst clears the flag.
- Redirect priority: ex_redirect = 1 with a simultaneous load-use -> if_id_flush = 1, id_ex_flush = 1, pc_en = 1. id_redirect alone -> only if_id_flush = 1.
- Reset mid-wait: rst during DMEM_WAIT -> next cycle all enables = 1 and state = RUN; with HAZARD_PERF_CNT_EN defined, all counters = 0.
